// File: rtl/icache_refill_fsm_pkg.sv
// Shared I-cache geometry, refill FSM state encoding and block word helpers.
// Imported by the refill controller, its interface and the fetch-stage bench.
package icache_refill_fsm_pkg;

  localparam int unsigned IWORD_BITS        = 32;
  localparam int unsigned IWORDS_PER_BLOCK  = 4;
  localparam int unsigned IBLOCK_SIZE_BITS  = IWORD_BITS * IWORDS_PER_BLOCK;
  localparam int unsigned ITAG_SIZE         = 23;
  localparam int unsigned ISET_INDEX_SIZE   = 5;
  localparam int unsigned IBLOCK_ADDR_BITS  = ITAG_SIZE + ISET_INDEX_SIZE;
  localparam int unsigned IBEAT_CNT_BITS    = 2;

  typedef logic [IWORD_BITS-1:0]       word_t;
  typedef logic [IBLOCK_SIZE_BITS-1:0] block_t;
  typedef logic [IBLOCK_ADDR_BITS-1:0] blk_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MISS_REQ = 3'd1,
    ST_REFILL   = 3'd2,
    ST_WRITE    = 3'd3,
    ST_REPLAY   = 3'd4
  } icache_state_e;

  // Word i of a block occupies bits 32i+31:32i.
  function automatic word_t block_word(input block_t blk, input logic [1:0] sel);
    word_t w;
    case (sel)
      2'd0:    w = blk[31:0];
      2'd1:    w = blk[63:32];
      2'd2:    w = blk[95:64];
      2'd3:    w = blk[127:96];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic block_t block_set_word(input block_t blk, input logic [1:0] sel,
                                            input word_t w);
    block_t r;
    r = blk;
    case (sel)
      2'd0:    r[31:0]   = w;
      2'd1:    r[63:32]  = w;
      2'd2:    r[95:64]  = w;
      2'd3:    r[127:96] = w;
      default: r = blk;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/icache_refill_fsm_if.sv
// Fetch-stage bundle around the refill controller: CPU fetch port, I-cache SRAM port,
// memory refill port and performance counters. master = controller, slave = environment.
interface icache_refill_fsm_if;
  import icache_refill_fsm_pkg::*;

  logic      cpu_req_i;
  logic [31:0] cpu_addr_i;
  word_t     cpu_instr_o;
  logic      cpu_stall_o;

  logic      sram_en_o;
  logic      sram_memWen_o;
  blk_addr_t sram_blockAddr_o;
  block_t    sram_dataIn_o;
  logic      sram_hit_i;
  block_t    sram_dataOut_i;

  logic      mem_req_o;
  logic [31:0] mem_addr_o;
  logic      mem_gnt_i;
  logic      mem_rvalid_i;
  word_t     mem_rdata_i;

  logic [31:0] stat_hits_o;
  logic [31:0] stat_misses_o;

  modport master (
    input  cpu_req_i, cpu_addr_i, sram_hit_i, sram_dataOut_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output cpu_instr_o, cpu_stall_o, sram_en_o, sram_memWen_o, sram_blockAddr_o,
           sram_dataIn_o, mem_req_o, mem_addr_o, stat_hits_o, stat_misses_o
  );

  modport slave (
    output cpu_req_i, cpu_addr_i, sram_hit_i, sram_dataOut_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  cpu_instr_o, cpu_stall_o, sram_en_o, sram_memWen_o, sram_blockAddr_o,
           sram_dataIn_o, mem_req_o, mem_addr_o, stat_hits_o, stat_misses_o
  );

endinterface

// File: rtl/icache_refill_fsm.sv
// I-cache refill controller: same-cycle hit service, 4-beat block refill, SRAM write, replay.
// Hit/miss performance counters are built only when ICACHE_STATS_EN is defined.
module icache_refill_fsm
  import icache_refill_fsm_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  icache_refill_fsm_if.master bus
);

  icache_state_e             state_q;
  logic [IBEAT_CNT_BITS-1:0] beat_q;
  block_t                    buf_q;
  blk_addr_t                 addr_q;
  logic                      mem_req_q;
  logic                      wen_q;

  logic      lookup_s;
  logic      stall_s;
  logic      miss_s;
  blk_addr_t blk_addr_s;
  logic      unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^bus.cpu_addr_i[1:0];

  // Lookup qualification, stall and SRAM block address per state
  always_comb begin
    lookup_s   = 1'b0;
    stall_s    = 1'b0;
    blk_addr_s = addr_q;
    case (state_q)
      ST_IDLE: begin
        lookup_s   = bus.cpu_req_i;
        stall_s    = bus.cpu_req_i & ~bus.sram_hit_i;
        blk_addr_s = bus.cpu_addr_i[31:4];
      end
      ST_REPLAY: begin
        lookup_s = bus.cpu_req_i;
        stall_s  = bus.cpu_req_i & ~bus.sram_hit_i;
      end
      ST_MISS_REQ, ST_REFILL, ST_WRITE: begin
        stall_s = 1'b1;
      end
      default: begin
        lookup_s = 1'b0;
        stall_s  = 1'b0;
      end
    endcase
  end

  assign miss_s = lookup_s & ~bus.sram_hit_i;

  // Held reset masks the combinational fetch-side outputs as well as the state.
  assign bus.cpu_stall_o      = rst & stall_s;
  assign bus.cpu_instr_o      = (rst && lookup_s) ?
                                block_word(bus.sram_dataOut_i, bus.cpu_addr_i[3:2]) :
                                32'h0000_0000;
  assign bus.sram_en_o        = rst & (lookup_s | wen_q);
  assign bus.sram_memWen_o    = wen_q;
  assign bus.sram_blockAddr_o = blk_addr_s;
  assign bus.sram_dataIn_o    = wen_q ? buf_q : bus.sram_dataOut_i;
  assign bus.mem_req_o        = mem_req_q;
  assign bus.mem_addr_o       = {addr_q, 4'h0};

  // Refill sequencer with registered mem_req and SRAM write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= {IBEAT_CNT_BITS{1'b0}};
      buf_q     <= {IBLOCK_SIZE_BITS{1'b0}};
      addr_q    <= {IBLOCK_ADDR_BITS{1'b0}};
      mem_req_q <= 1'b0;
      wen_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_s) begin
            state_q   <= ST_MISS_REQ;
            addr_q    <= bus.cpu_addr_i[31:4];
            mem_req_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MISS_REQ: begin
          if (bus.mem_gnt_i) begin
            state_q   <= ST_REFILL;
            mem_req_q <= 1'b0;
            beat_q    <= {IBEAT_CNT_BITS{1'b0}};
          end
        end
        ST_REFILL: begin
          if (bus.mem_rvalid_i) begin
            buf_q  <= block_set_word(buf_q, beat_q, bus.mem_rdata_i);
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              state_q <= ST_WRITE;
              wen_q   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          wen_q   <= 1'b0;
          state_q <= ST_REPLAY;
        end
        ST_REPLAY: begin
          // A replay miss reuses the captured block address; cpu_addr is held while stalled.
          if (miss_s) begin
            state_q   <= ST_MISS_REQ;
            mem_req_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          wen_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  // Only first-look IDLE outcomes count; replay hits are the tail of a counted miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= 32'h0000_0000;
      misses_q <= 32'h0000_0000;
    end else begin
      if ((state_q == ST_IDLE) && lookup_s && bus.sram_hit_i) begin
        hits_q <= hits_q + 32'd1;
      end
      if ((state_q == ST_IDLE) && miss_s) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign bus.stat_hits_o   = hits_q;
  assign bus.stat_misses_o = misses_q;
`else
  assign bus.stat_hits_o   = 32'h0000_0000;
  assign bus.stat_misses_o = 32'h0000_0000;
`endif

endmodule

// File: doc/icache_refill_fsm.md
ICACHE_REFILL_FSM -- requirements
Module: icache_refill_fsm

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 cpu_req  input  1  fetch request; cpu_addr held stable while cpu_stall=1.
REQ-004 cpu_addr  input  32  byte address of fetched instruction.
REQ-005 cpu_instr  output  32  fetched word; valid when cpu_req=1 and cpu_stall=0.
REQ-006 cpu_stall  output  1  1 = fetch not served this cycle.
REQ-007 sram_en, sram_memWen  output  1 each  I-cache SRAM enable and refill write strobe.
REQ-008 sram_blockAddr  output  ITAG_SIZE+ISET_INDEX_SIZE  = cpu_addr[31:4] (tag 23 b, index 5 b).
REQ-009 sram_dataIn  output  IBLOCK_SIZE_BITS (128)  block written to SRAM.
REQ-010 sram_hit, sram_dataOut  input  1, 128  combinational SRAM lookup result.
REQ-011 mem_req  output  1, mem_addr  output  32  block read request to memory.
REQ-012 mem_gnt  input  1  request accepted; mem_rvalid  input  1, mem_rdata  input  32  one refill beat per mem_rvalid.
REQ-013 stat_hits, stat_misses  output  32 each  performance counters (see Configuration).

Function
REQ-014 States: IDLE, MISS_REQ, REFILL, WRITE, REPLAY; encoding free.
REQ-015 IDLE, cpu_req=1: sram_en=1, sram_memWen=0, sram_dataIn=sram_dataOut (hit write-back preserves data, updates PLRU).
REQ-016 IDLE hit: cpu_stall=0 same cycle, cpu_instr=sram_dataOut word cpu_addr[3:2] (word i = bits 32i+31:32i); state stays IDLE.
REQ-017 IDLE miss: cpu_stall=1 same cycle, next state MISS_REQ, capture block address {cpu_addr[31:4],4'h0}.
REQ-018 IDLE, cpu_req=0: sram_en=0, cpu_stall=0.
REQ-019 MISS_REQ: mem_req=1, mem_addr=captured address, held until cycle with mem_gnt=1; then REFILL, beat counter=0.
REQ-020 REFILL: each cycle with mem_rvalid=1 stores mem_rdata into buffer word[counter], counter+1; after beat 3 go to WRITE.
REQ-021 mem_rvalid outside REFILL ignored; mem_gnt outside MISS_REQ ignored.
REQ-022 WRITE: one cycle, sram_en=1, sram_memWen=1, sram_blockAddr=captured address, sram_dataIn=buffer; next REPLAY.
REQ-023 REPLAY: as IDLE lookup; hit serves cpu_stall=0 and returns to IDLE; miss (not expected) re-enters MISS_REQ.
REQ-024 cpu_stall=1 in MISS_REQ, REFILL, WRITE; minimum miss penalty = 1 (MISS_REQ, gnt immediate) + 4 beats + 1 WRITE, served in REPLAY.
REQ-025 cpu_req dropped mid-refill: refill completes and block is written; REPLAY with cpu_req=0 returns to IDLE without lookup.
REQ-026 Non-IDLE states: SRAM block address from captured register, never from live cpu_addr.

Reset
REQ-027 rst=0 asynchronously forces IDLE, counter=0, buffer=0, captured address=0, stat counters=0.
REQ-028 During reset: cpu_stall=0, cpu_instr=0, mem_req=0, sram_en=0, sram_memWen=0; abandoned refill never writes SRAM.

Configuration
REQ-029 Macro ICACHE_STATS_EN defined: stat_hits +1 per IDLE hit with cpu_req=1, stat_misses +1 per IDLE->MISS_REQ transition; REPLAY hits not counted; counters wrap at 2^32.
REQ-030 ICACHE_STATS_EN undefined: counter logic absent, stat_hits and stat_misses tied 0.

Structure
REQ-031 Shared constants package (constants.vh): IBLOCK_SIZE_BITS, ITAG_SIZE, ISET_INDEX_SIZE, words-per-block (4), state encodings.
REQ-032 Single module, no sub-modules; instantiated beside Icache_SRAM in the fetch stage.

Verification
REQ-033 Reset, cpu_req=1 addr 0x0000_0040 -> miss, mem_addr=0x0000_0040, after gnt + beats 0x11,0x22,0x33,0x44 -> REPLAY cpu_instr=0x11, stall drops.
REQ-034 Then fetch 0x0000_004C -> same-cycle hit, cpu_instr=0x44, cpu_stall=0, no mem_req.
REQ-035 mem_gnt delayed 5 cycles, mem_rvalid gaps between beats -> mem_req held, beats stored in order, exactly one sram_memWen pulse.
REQ-036 rst asserted after beat 2 -> mem_req=0 immediately, no SRAM write; refetch of same address misses again.
REQ-037 cpu_req dropped during REFILL -> WRITE still occurs, later fetch of that block hits.
REQ-038 ICACHE_STATS_EN: 1 miss + 3 hits -> stat_misses=1, stat_hits=3; undefined -> both 0.
